control_umbrales: RTL
=====================

# control_umbrales

Occupancy tracker and flow-control generator for the ten transaction-layer FIFOs. It counts push/pop strobes per FIFO and compares each occupancy against the high/low thresholds produced by the transaction-layer state machine. From that it generates per-FIFO pause with hysteresis, plus the registered `FIFO_empty`/`FIFO_full` vectors that the state machine consumes. It sits beside the FIFO bank, between the state machine's threshold outputs and the upstream writers.

## Interface
- `N_FIFO`, 10, number of tracked FIFOs
- `DEPTH`, 8, entries per FIFO; occupancy range 0..DEPTH
- `OCC_W`, 4, occupancy width, must hold DEPTH
- `TH_W`, 3, threshold width
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `cargar`  in  1  one-cycle strobe: latch thresholds
- `umbral_alto`  in  TH_W  high threshold (state machine `interno_alto`)
- `umbral_bajo`  in  TH_W  low threshold (state machine `interno_bajo`)
- `push`  in  N_FIFO  per-FIFO write strobe
- `pop`  in  N_FIFO  per-FIFO read strobe
- `FIFO_empty`  out  N_FIFO  occupancy == 0
- `FIFO_full`  out  N_FIFO  occupancy == DEPTH
- `pausa`  out  N_FIFO  hysteretic back-pressure to the writers
- `error_cfg`  out  1  one-cycle pulse when a load is rejected
- `error_overflow`  out  N_FIFO  sticky; see Configuration
- `error_underflow`  out  N_FIFO  sticky; see Configuration

## Operation
- **Reset state:**
  - All occupancies 0.
  - `FIFO_empty` = all ones; `FIFO_full`, `pausa`, `error_cfg`, `error_overflow`, `error_underflow` = 0.
  - Latched thresholds: alto = 6, bajo = 2.
- **Threshold load:**
  - On `cargar` with `umbral_bajo < umbral_alto`, latch both values.
  - Otherwise keep the previous pair and pulse `error_cfg`.
  - `cargar` during `reset` is ignored.
- **Per-FIFO occupancy update, evaluated in this order:**
  - Push and pop both valid: occupancy unchanged.
  - Push only, below DEPTH: occupancy +1.
  - Pop only, above 0: occupancy −1.
  - Pop at 0: pop discarded (underflow); a simultaneous push still applies, so occupancy becomes 1.
  - Push at DEPTH with no pop: push discarded (overflow); occupancy stays at DEPTH.
  - Push at DEPTH with simultaneous pop: legal, occupancy unchanged.
- **Pause per FIFO, using the new occupancy (`occ`):**
  - Set when `occ >= alto`.
  - Clear when `occ <= bajo`.
  - Hold otherwise.
  - Compare with zero-extended thresholds. Occupancy never wraps.
- **Threshold change effect:**
  - A new threshold pair takes effect on the cycle after it is latched.
  - Existing `pausa` bits are re-evaluated against the new pair.

## Timing
- All outputs are registered.
- A push/pop strobe sampled at edge k is reflected in `FIFO_empty`, `FIFO_full` and `pausa` after edge k: one cycle latency.
- `error_cfg` is high for exactly the cycle after the rejected `cargar` edge.
- **Reset mid-operation:**
  - Reset wins over push, pop and `cargar` in the same cycle.
  - All state returns to the reset values on the next edge.
- Strobes carry no handshake. The FIFO bank guarantees that a strobe lasts exactly one cycle per transfer.

## Configuration
- Macro: `CONTROL_UMBRALES_ERRORES_EN`.
- **Defined:**
  - `error_overflow[i]` / `error_underflow[i]` set on the cycle after a discarded push / pop.
  - They stay set until `reset`.
- **Undefined:**
  - Both outputs are tied to 0.
  - Discarded push/pop handling is unchanged.
  - No error registers are synthesised.

## Structure
- **Shared package:**
  - `N_FIFO`, `DEPTH`, `OCC_W`, `TH_W` defaults.
  - Reset threshold constants ALTO_RST = 6 and BAJO_RST = 2, shared with the state machine.
- **Sub-module `contador_umbral`:**
  - One FIFO slice: occupancy counter, empty/full flags, pause hysteresis, error flags.
  - Instantiated N_FIFO times via generate.
  - Threshold latch and `error_cfg` logic stay in the top module.

## Test plan
- **Reset and defaults:** assert `reset` 2 cycles → `FIFO_empty` = 10'h3FF, `pausa` = 0. Then 6 pushes on FIFO 3 → `pausa[3]` rises the cycle after the 6th push.
- **Hysteresis:** from occupancy 6 with `pausa[3]` = 1, pop to 3 → pause held. Pop to 2 → `pausa[3]` = 0 one cycle later.
- **Full and overflow:** 9 pushes on FIFO 0 → occupancy 8, `FIFO_full[0]` = 1. With the macro defined, `error_overflow[0]` = 1 after the 9th push. Simultaneous push+pop at full → occupancy stays 8, no error.
- **Empty and underflow:** pop on empty FIFO 9 → `FIFO_empty[9]` stays 1, `error_underflow[9]` = 1 (macro defined). Push+pop at empty → occupancy 1.
- **Configuration load:** `cargar` with alto = 4, bajo = 1 → pause now asserts at 4. `cargar` with alto = 2, bajo = 5 → `error_cfg` pulses 1 cycle, thresholds stay at 4/1.
- **Reset mid-traffic:** `reset` asserted together with push on all FIFOs → next cycle all empty, `pausa` = 0, thresholds back to 6/2.

Source files
------------

// File: rtl/control_umbrales_pkg.sv
// Shared constants for the transaction-layer FIFO occupancy tracker.
// Reset thresholds are also consumed by the transaction-layer state machine.
package control_umbrales_pkg;
  localparam int N_FIFO   = 10;
  localparam int DEPTH    = 8;
  localparam int OCC_W    = 4;
  localparam int TH_W     = 3;
  localparam int ALTO_RST = 6;
  localparam int BAJO_RST = 2;
endpackage

// File: rtl/control_umbrales_contador_umbral.sv
// One FIFO slice: occupancy counter, empty/full flags and hysteretic pause.
// Sticky overflow/underflow flags exist only with CONTROL_UMBRALES_ERRORES_EN.
module contador_umbral
  import control_umbrales_pkg::*;
#(
  parameter int DEPTH = control_umbrales_pkg::DEPTH,
  parameter int OCC_W = control_umbrales_pkg::OCC_W,
  parameter int TH_W  = control_umbrales_pkg::TH_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [TH_W-1:0] alto,
  input  logic [TH_W-1:0] bajo,
  output logic            fifo_empty,
  output logic            fifo_full,
  output logic            pausa,
  output logic            error_overflow,
  output logic            error_underflow
);
  localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(DEPTH);

  logic [OCC_W-1:0] occ_q, occ_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             pausa_q, pausa_d;
  logic             at_zero, at_max;

  assign at_zero = (occ_q == '0);
  assign at_max  = (occ_q == OCC_MAX);

  always_comb begin
    occ_d = occ_q;
    // A pop at zero is dropped, so a paired push still lands.
    if (push && pop) begin
      if (at_zero) occ_d = OCC_W'(1);
    end else if (push) begin
      if (!at_max) occ_d = occ_q + 1'b1;
    end else if (pop) begin
      if (!at_zero) occ_d = occ_q - 1'b1;
    end

    empty_d = (occ_d == '0);
    full_d  = (occ_d == OCC_MAX);

    pausa_d = pausa_q;
    if (occ_d >= OCC_W'(alto))      pausa_d = 1'b1;
    else if (occ_d <= OCC_W'(bajo)) pausa_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      pausa_q <= 1'b0;
    end else begin
      occ_q   <= occ_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      pausa_q <= pausa_d;
    end
  end

  assign fifo_empty = empty_q;
  assign fifo_full  = full_q;
  assign pausa      = pausa_q;

`ifdef CONTROL_UMBRALES_ERRORES_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  always_comb begin
    ovf_d = ovf_q | (push & ~pop & at_max);
    unf_d = unf_q | (pop & at_zero);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign error_overflow  = ovf_q;
  assign error_underflow = unf_q;
`else
  assign error_overflow  = 1'b0;
  assign error_underflow = 1'b0;
`endif
endmodule

// File: rtl/control_umbrales.sv
// Occupancy tracker and flow-control generator for the transaction-layer FIFOs.
// Optional sticky overflow/underflow flags: define CONTROL_UMBRALES_ERRORES_EN.
module control_umbrales
  import control_umbrales_pkg::*;
#(
  parameter int N_FIFO = control_umbrales_pkg::N_FIFO,
  parameter int DEPTH  = control_umbrales_pkg::DEPTH,
  parameter int OCC_W  = control_umbrales_pkg::OCC_W,
  parameter int TH_W   = control_umbrales_pkg::TH_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cargar,
  input  logic [TH_W-1:0]   umbral_alto,
  input  logic [TH_W-1:0]   umbral_bajo,
  input  logic [N_FIFO-1:0] push,
  input  logic [N_FIFO-1:0] pop,
  output logic [N_FIFO-1:0] FIFO_empty,
  output logic [N_FIFO-1:0] FIFO_full,
  output logic [N_FIFO-1:0] pausa,
  output logic              error_cfg,
  output logic [N_FIFO-1:0] error_overflow,
  output logic [N_FIFO-1:0] error_underflow
);
  logic [TH_W-1:0] alto_q, alto_d;
  logic [TH_W-1:0] bajo_q, bajo_d;
  logic            error_cfg_q, error_cfg_d;

  always_comb begin
    alto_d      = alto_q;
    bajo_d      = bajo_q;
    error_cfg_d = 1'b0;
    if (cargar) begin
      if (umbral_bajo < umbral_alto) begin
        alto_d = umbral_alto;
        bajo_d = umbral_bajo;
      end else begin
        error_cfg_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alto_q      <= TH_W'(ALTO_RST);
      bajo_q      <= TH_W'(BAJO_RST);
      error_cfg_q <= 1'b0;
    end else begin
      alto_q      <= alto_d;
      bajo_q      <= bajo_d;
      error_cfg_q <= error_cfg_d;
    end
  end

  assign error_cfg = error_cfg_q;

  // Slices see the latched pair, so a new pair applies from the next cycle.
  for (genvar i = 0; i < N_FIFO; i++) begin : g_fifo
    contador_umbral #(
      .DEPTH (DEPTH),
      .OCC_W (OCC_W),
      .TH_W  (TH_W)
    ) u_slice (
      .clk             (clk),
      .reset           (reset),
      .push            (push[i]),
      .pop             (pop[i]),
      .alto            (alto_q),
      .bajo            (bajo_q),
      .fifo_empty      (FIFO_empty[i]),
      .fifo_full       (FIFO_full[i]),
      .pausa           (pausa[i]),
      .error_overflow  (error_overflow[i]),
      .error_underflow (error_underflow[i])
    );
  end
endmodule
